// File: rtl/regfile_2r1w.sv
// regfile_2r1w: architectural register file, NREGS x WIDTH.
// It has two combinational read ports and one synchronous write port.
// Each row is a bank of flops. A per-row decoded enable is gated by RegWrite, and a
// hold path keeps the row value when the enable is low.
// Row ZERO_REG has no storage and always reads zero.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, write-through
// forwarding sends WriteData to a read port that addresses the row being written.
module regfile_2r1w #(
  parameter  int WIDTH    = 64,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 31,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  // Flattened view of every row. The zero row is a constant, not a flop.
  logic [NREGS-1:0][WIDTH-1:0] rows_s;
  logic [WIDTH-1:0]            rd1_s;
  logic [WIDTH-1:0]            rd2_s;

  for (genvar r = 0; r < NREGS; r++) begin : g_row
    if (r == ZERO_REG) begin : g_zero
      assign rows_s[r] = {WIDTH{1'b0}};
    end else begin : g_flop
      logic             wen_s;
      logic [WIDTH-1:0] row_r;

      // RegWrite gates the enable, so an unknown write enable only touches the addressed row.
      assign wen_s = RegWrite && (WriteRegister == AW'(r));

      // Row storage: asynchronous clear, load when enabled, otherwise hold.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          row_r <= {WIDTH{1'b0}};
        end else if (wen_s) begin
          row_r <= WriteData;
        end else begin
          row_r <= row_r;
        end
      end

      assign rows_s[r] = row_r;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1_s;
  logic fwd2_s;

  // Forward only a live write to a real row. Reset keeps the ports at zero.
  assign fwd1_s = reset && RegWrite && (WriteRegister != AW'(ZERO_REG)) &&
                  (WriteRegister == ReadRegister1);
  assign fwd2_s = reset && RegWrite && (WriteRegister != AW'(ZERO_REG)) &&
                  (WriteRegister == ReadRegister2);

  // Read muxes with write-through forwarding for a same-cycle WB->ID hand-off.
  always_comb begin
    rd1_s = rows_s[ReadRegister1];
    rd2_s = rows_s[ReadRegister2];
    if (fwd1_s) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = rows_s[ReadRegister1];
    end
    if (fwd2_s) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = rows_s[ReadRegister2];
    end
  end
`else
  // Plain read muxes. A row being written shows its old value until the edge.
  always_comb begin
    rd1_s = rows_s[ReadRegister1];
    rd2_s = rows_s[ReadRegister2];
  end
`endif

  assign ReadData1 = rd1_s;
  assign ReadData2 = rd2_s;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w. A simple array model tracks the register contents.
// Works for both builds: the expected read honours REGFILE_BYPASS_EN when defined.
module tb_regfile_2r1w;
  localparam int WIDTH    = 64;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;
  localparam int AW       = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             RegWrite;
  logic [AW-1:0]    WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [AW-1:0]    ReadRegister1;
  logic [AW-1:0]    ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  logic [WIDTH-1:0] model [NREGS];
  int checks = 0;
  int errors = 0;

  regfile_2r1w dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  // Expected read value from the model and the current write inputs.
  function automatic logic [WIDTH-1:0] expect_rd(input logic [AW-1:0] ra);
    if (int'(ra) == ZERO_REG) return '0;
    if (!reset) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteRegister == ra) return WriteData;
`endif
    return model[ra];
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_rd1"}, ReadData1, expect_rd(ReadRegister1));
    check({tag, "_rd2"}, ReadData2, expect_rd(ReadRegister2));
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
  endtask

  // Called just after a negedge with inputs driven: check before the edge, clock it, check after it.
  task automatic step(input string tag);
    #1;
    check_ports({tag, "_pre"});
    @(posedge clk);
    if (reset && RegWrite && int'(WriteRegister) != ZERO_REG) model[WriteRegister] = WriteData;
    #1;
    check_ports({tag, "_post"});
    @(negedge clk);
  endtask

  task automatic sweep_all(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      ReadRegister1 = AW'(i);
      ReadRegister2 = AW'(NREGS - 1 - i);
      #1;
      check_ports(tag);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] exp_pre;
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    // 1: reset held, then released; every index reads zero.
    reset = 1'b0;
    drive(1'b1, 5'd3, 64'hFFFF_0000_FFFF_0000, 5'd3, 5'd0);
    @(posedge clk); #1;
    check_ports("t1_in_reset");
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    sweep_all("t1_sweep");
    @(negedge clk);

    // 2: write row 5, read 5 and 6.
    drive(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5, 5'd6);
    step("t2");
    check("t2_row5", ReadData1, 64'hDEAD_BEEF_0123_4567);
    check("t2_row6", ReadData2, 64'd0);

    // 3: write to the zero register is dropped; other rows unchanged.
    drive(1'b1, 5'd31, {WIDTH{1'b1}}, 5'd31, 5'd5);
    step("t3");
    check("t3_row31", ReadData1, 64'd0);
    sweep_all("t3_sweep");
    @(negedge clk);

    // 4: RegWrite=0 changes nothing.
    drive(1'b0, 5'd5, 64'd0, 5'd5, 5'd31);
    step("t4");
    check("t4_row5", ReadData1, 64'hDEAD_BEEF_0123_4567);

    // 5: same-cycle write and read of row 7.
    drive(1'b1, 5'd7, 64'd1, 5'd7, 5'd7);
    step("t5_init");
`ifdef REGFILE_BYPASS_EN
    exp_pre = 64'd2;
`else
    exp_pre = 64'd1;
`endif
    drive(1'b1, 5'd7, 64'd2, 5'd7, 5'd8);
    #1;
    check("t5_before_edge", ReadData1, exp_pre);
    @(posedge clk);
    model[7] = 64'd2;
    #1;
    check("t5_after_edge", ReadData1, 64'd2);
    @(negedge clk);

    // Random traffic with frequent read/write address collisions and zero-register writes.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, NREGS - 1));
      drive(($urandom_range(0, 3) != 0), wa, {$urandom(), $urandom()},
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREGS - 1)),
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREGS - 1)));
      step("rand");
    end

    // 6: rows 0..30 = index*3, then reset mid-cycle with a write pending.
    for (int i = 0; i < ZERO_REG; i++) begin
      drive(1'b1, AW'(i), WIDTH'(i * 3), AW'(i), AW'(ZERO_REG));
      step("t6_fill");
    end
    drive(1'b0, 5'd0, 64'd0, 5'd10, 5'd30);
    #1;
    check("t6_row10_filled", ReadData1, 64'd30);
    check("t6_row30_filled", ReadData2, 64'd90);
    drive(1'b1, 5'd4, 64'h1234_5678_9ABC_DEF0, 5'd4, 5'd10);
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    #1;
    check("t6_reset_now_rd1", ReadData1, 64'd0);
    check("t6_reset_now_rd2", ReadData2, 64'd0);
    @(posedge clk); #1;
    check_ports("t6_reset_edge");
    @(negedge clk);
    sweep_all("t6_in_reset");
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd4, 64'd0, 5'd4, 5'd10);
    @(posedge clk); #1;
    sweep_all("t6_released");
    @(negedge clk);
    drive(1'b1, 5'd10, 64'd77, 5'd10, 5'd11);
    step("t6_rewrite");
    check("t6_row10_rewritten", ReadData1, 64'd77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
